// File: rtl/sdram_arbit.sv
// -----------------------------------------------------------------------------
// sdram_arbit
//
// Purpose:
//   Command arbiter between the SDRAM init, auto-refresh, write and read
//   sub-controllers and the SDRAM pins. The bus belongs to the init sequence
//   until init_end. After that, one requester at a time gets the bus by fixed
//   priority: refresh > write > read. A grant is never pre-empted. The granted
//   block's {cmd, bank, addr} goes to the pins, and the write block's data goes
//   to the DQ output path.
//
// Ports:
//   ar_clk, ar_rst_n              clock, async active-low reset
//   init_end/cmd/bank/addr        init sequencer (init_end is a level)
//   ar_req/end/cmd/bank/addr      auto-refresh block (req level, end pulse)
//   wr_req/end/cmd/bank/addr      write block (req level, end pulse)
//   wr_sdram_en, wr_data          write block DQ drive enable and data
//   rd_req/end/cmd/bank/addr      read block (req level, end pulse)
//   ar_en, wr_en, rd_en           grants, decoded from the state register only
//   sdram_cke                     clock enable, registered, low during reset
//   sdram_cs_n/ras_n/cas_n/we_n   command pins
//   sdram_ba, sdram_addr          bank / address pins
//   sdram_dq_out, sdram_dq_oe     DQ data and output enable (tristate built above)
// -----------------------------------------------------------------------------
module sdram_arbit #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 13,
  parameter int BANK_W = 2
) (
  input  logic              ar_clk,
  input  logic              ar_rst_n,
  input  logic              init_end,
  input  logic [3:0]        init_cmd,
  input  logic [BANK_W-1:0] init_bank,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic              ar_req,
  input  logic              ar_end,
  input  logic [3:0]        ar_cmd,
  input  logic [BANK_W-1:0] ar_bank,
  input  logic [ADDR_W-1:0] ar_addr,
  input  logic              wr_req,
  input  logic              wr_end,
  input  logic [3:0]        wr_cmd,
  input  logic [BANK_W-1:0] wr_bank,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_sdram_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_req,
  input  logic              rd_end,
  input  logic [3:0]        rd_cmd,
  input  logic [BANK_W-1:0] rd_bank,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              ar_en,
  output logic              wr_en,
  output logic              rd_en,
  output logic              sdram_cke,
  output logic              sdram_cs_n,
  output logic              sdram_ras_n,
  output logic              sdram_cas_n,
  output logic              sdram_we_n,
  output logic [BANK_W-1:0] sdram_ba,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [DATA_W-1:0] sdram_dq_out,
  output logic              sdram_dq_oe
);

  localparam logic [3:0] CMD_NOP = 4'b0111;

  typedef enum logic [2:0] {
    INIT,
    ARBIT,
    AREF,
    WRITE,
    READ
  } state_t;

  state_t     state_q, state_d;
  logic       cke_q;
  logic [3:0] cmd_sel;

  // State and CKE registers. CKE comes up on the first clock after reset
  // release, so the SDRAM sees a clean low-to-high transition.
  always_ff @(posedge ar_clk or negedge ar_rst_n) begin
    if (!ar_rst_n) begin
      state_q <= INIT;
      cke_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cke_q   <= 1'b1;
    end
  end

  // Next-state logic. Every grant passes back through ARBIT, so at least one
  // idle cycle separates consecutive grants. A request that arrives with an
  // end pulse is evaluated on that ARBIT cycle. End pulses from blocks that do
  // not hold the bus have no effect.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      INIT:  if (init_end) state_d = ARBIT;
      ARBIT: begin
        if (ar_req)      state_d = AREF;
        else if (wr_req) state_d = WRITE;
        else if (rd_req) state_d = READ;
      end
      AREF:  if (ar_end) state_d = ARBIT;
      WRITE: if (wr_end) state_d = ARBIT;
      READ:  if (rd_end) state_d = ARBIT;
      default: state_d = INIT;
    endcase
  end

  // Grants and the pin mux depend only on the state register, so a request
  // input never reaches a grant combinationally. ARBIT drives a NOP with the
  // bank and address all-ones.
  always_comb begin
    ar_en       = 1'b0;
    wr_en       = 1'b0;
    rd_en       = 1'b0;
    cmd_sel     = CMD_NOP;
    sdram_ba    = '1;
    sdram_addr  = '1;
    sdram_dq_oe = 1'b0;
    unique case (state_q)
      INIT: begin
        cmd_sel    = init_cmd;
        sdram_ba   = init_bank;
        sdram_addr = init_addr;
      end
      AREF: begin
        ar_en      = 1'b1;
        cmd_sel    = ar_cmd;
        sdram_ba   = ar_bank;
        sdram_addr = ar_addr;
      end
      WRITE: begin
        wr_en       = 1'b1;
        cmd_sel     = wr_cmd;
        sdram_ba    = wr_bank;
        sdram_addr  = wr_addr;
        sdram_dq_oe = wr_sdram_en;
      end
      READ: begin
        rd_en      = 1'b1;
        cmd_sel    = rd_cmd;
        sdram_ba   = rd_bank;
        sdram_addr = rd_addr;
      end
      default: ;
    endcase
  end

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd_sel;
  assign sdram_dq_out = wr_data;
  assign sdram_cke    = cke_q;

endmodule

// File: tb/tb_sdram_arbit.sv
// -----------------------------------------------------------------------------
// tb_sdram_arbit
//
// Testbench for sdram_arbit. A directed sequence covers init handover,
// refresh, simultaneous requests, no pre-emption, DQ enable gating and async
// reset, with hand-computed literal expectations. A randomized phase follows.
// Throughout both phases, a behavioural model tracks which requester owns the
// bus, and a compare process checks every DUT output against it on every
// falling edge.
// -----------------------------------------------------------------------------
module tb_sdram_arbit;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 13;
  localparam int BANK_W = 2;

  localparam int OWN_NONE = 0;
  localparam int OWN_AR   = 1;
  localparam int OWN_WR   = 2;
  localparam int OWN_RD   = 3;

  logic              ar_clk = 1'b0;
  logic              ar_rst_n;
  logic              init_end;
  logic [3:0]        init_cmd;
  logic [BANK_W-1:0] init_bank;
  logic [ADDR_W-1:0] init_addr;
  logic              ar_req, ar_end;
  logic [3:0]        ar_cmd;
  logic [BANK_W-1:0] ar_bank;
  logic [ADDR_W-1:0] ar_addr;
  logic              wr_req, wr_end, wr_sdram_en;
  logic [3:0]        wr_cmd;
  logic [BANK_W-1:0] wr_bank;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_req, rd_end;
  logic [3:0]        rd_cmd;
  logic [BANK_W-1:0] rd_bank;
  logic [ADDR_W-1:0] rd_addr;

  logic              ar_en, wr_en, rd_en, sdram_cke;
  logic              sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [BANK_W-1:0] sdram_ba;
  logic [ADDR_W-1:0] sdram_addr;
  logic [DATA_W-1:0] sdram_dq_out;
  logic              sdram_dq_oe;

  int checks   = 0;
  int failures = 0;
  bit cmpEn    = 1'b0;

  // Model state: has the init sequence handed over, who owns the bus, and CKE.
  bit mInitDone;
  int mOwner;
  bit mCke;

  sdram_arbit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BANK_W(BANK_W)) dut (
    .ar_clk(ar_clk), .ar_rst_n(ar_rst_n),
    .init_end(init_end), .init_cmd(init_cmd), .init_bank(init_bank), .init_addr(init_addr),
    .ar_req(ar_req), .ar_end(ar_end), .ar_cmd(ar_cmd), .ar_bank(ar_bank), .ar_addr(ar_addr),
    .wr_req(wr_req), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_bank(wr_bank), .wr_addr(wr_addr),
    .wr_sdram_en(wr_sdram_en), .wr_data(wr_data),
    .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_bank(rd_bank), .rd_addr(rd_addr),
    .ar_en(ar_en), .wr_en(wr_en), .rd_en(rd_en), .sdram_cke(sdram_cke),
    .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n), .sdram_cas_n(sdram_cas_n),
    .sdram_we_n(sdram_we_n), .sdram_ba(sdram_ba), .sdram_addr(sdram_addr),
    .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe)
  );

  // 100 MHz clock
  always #5 ar_clk = ~ar_clk;

  // Single comparison point: counts every check and reports any difference.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Ownership model. Until init_end the init sequencer owns the bus. After
  // that, an idle bus goes to the highest-priority request present on a clock
  // edge, and a busy bus becomes idle again only on its own owner's end pulse.
  always @(posedge ar_clk or negedge ar_rst_n) begin
    if (!ar_rst_n) begin
      mInitDone <= 1'b0;
      mOwner    <= OWN_NONE;
      mCke      <= 1'b0;
    end else begin
      mCke <= 1'b1;
      if (!mInitDone) begin
        mInitDone <= init_end;
      end else if (mOwner == OWN_NONE) begin
        if (ar_req)      mOwner <= OWN_AR;
        else if (wr_req) mOwner <= OWN_WR;
        else if (rd_req) mOwner <= OWN_RD;
      end else if ((mOwner == OWN_AR && ar_end) || (mOwner == OWN_WR && wr_end) ||
                   (mOwner == OWN_RD && rd_end)) begin
        mOwner <= OWN_NONE;
      end
    end
  end

  // Compare every DUT output with what the model's owner implies.
  always @(negedge ar_clk) begin
    if (cmpEn) begin
      logic [3:0]        eCmd;
      logic [BANK_W-1:0] eBa;
      logic [ADDR_W-1:0] eAddr;
      if (!mInitDone) begin
        eCmd = init_cmd; eBa = init_bank; eAddr = init_addr;
      end else begin
        case (mOwner)
          OWN_AR:  begin eCmd = ar_cmd; eBa = ar_bank; eAddr = ar_addr; end
          OWN_WR:  begin eCmd = wr_cmd; eBa = wr_bank; eAddr = wr_addr; end
          OWN_RD:  begin eCmd = rd_cmd; eBa = rd_bank; eAddr = rd_addr; end
          default: begin eCmd = 4'b0111; eBa = '1; eAddr = '1; end
        endcase
      end
      checkOutput("model ar_en", 32'(ar_en), 32'(mInitDone && mOwner == OWN_AR));
      checkOutput("model wr_en", 32'(wr_en), 32'(mInitDone && mOwner == OWN_WR));
      checkOutput("model rd_en", 32'(rd_en), 32'(mInitDone && mOwner == OWN_RD));
      checkOutput("model cke", 32'(sdram_cke), 32'(mCke));
      checkOutput("model cmd", 32'({sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}), 32'(eCmd));
      checkOutput("model ba", 32'(sdram_ba), 32'(eBa));
      checkOutput("model addr", 32'(sdram_addr), 32'(eAddr));
      checkOutput("model dq_out", 32'(sdram_dq_out), 32'(wr_data));
      checkOutput("model dq_oe", 32'(sdram_dq_oe),
                  32'(mInitDone && mOwner == OWN_WR && wr_sdram_en));
    end
  end

  // Inputs change and literal checks happen 1 ns after the rising edge.
  task automatic nextCycle();
    @(posedge ar_clk);
    #1;
  endtask

  task automatic checkGrants(input string name, input logic [2:0] expected);
    checkOutput(name, 32'({ar_en, wr_en, rd_en}), 32'(expected));
  endtask

  task automatic checkCmd(input string name, input logic [3:0] expected);
    checkOutput(name, 32'({sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}), 32'(expected));
  endtask

  // Randomizes every data-like input. Request, end and reset inputs are left
  // to the caller.
  task automatic applyStimulus();
    init_cmd  = 4'($urandom); init_bank = 2'($urandom); init_addr = 13'($urandom);
    ar_cmd    = 4'($urandom); ar_bank   = 2'($urandom); ar_addr   = 13'($urandom);
    wr_cmd    = 4'($urandom); wr_bank   = 2'($urandom); wr_addr   = 13'($urandom);
    rd_cmd    = 4'($urandom); rd_bank   = 2'($urandom); rd_addr   = 13'($urandom);
    wr_data   = 16'($urandom); wr_sdram_en = 1'($urandom);
  endtask

  initial begin
    int initWait;
    ar_rst_n = 1'b0; init_end = 1'b0;
    ar_req = 1'b0; ar_end = 1'b0; wr_req = 1'b0; wr_end = 1'b0;
    rd_req = 1'b0; rd_end = 1'b0;
    applyStimulus();
    wr_sdram_en = 1'b0;
    init_cmd = 4'b0010; init_bank = 2'd1; init_addr = 13'h0400;
    ar_cmd = 4'b0001; wr_cmd = 4'b0100; rd_cmd = 4'b0101;
    cmpEn = 1'b1;

    // T1: init owns the bus until init_end
    nextCycle();
    checkGrants("reset grants", 3'b000);
    checkOutput("reset cke", 32'(sdram_cke), 32'd0);
    checkCmd("reset cmd is init", 4'b0010);
    nextCycle();
    ar_rst_n = 1'b1;
    nextCycle();
    checkCmd("T1 init cmd", 4'b0010);
    checkGrants("T1 no grants", 3'b000);
    checkOutput("T1 cke up", 32'(sdram_cke), 32'd1);
    init_end = 1'b1;
    nextCycle();
    checkCmd("T1 nop", 4'b0111);
    checkOutput("T1 ba", 32'(sdram_ba), 32'h3);
    checkOutput("T1 addr", 32'(sdram_addr), 32'h1fff);

    // T2: single refresh
    ar_req = 1'b1;
    nextCycle();
    checkGrants("T2 ar_en", 3'b100);
    checkCmd("T2 ar_cmd", 4'b0001);
    ar_req = 1'b0;
    nextCycle();
    ar_end = 1'b1;
    nextCycle();
    ar_end = 1'b0;
    checkGrants("T2 ar_en drop", 3'b000);
    checkCmd("T2 nop", 4'b0111);

    // T3/T4/T5: all three requests at once, refresh arrives again mid-write
    ar_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
    nextCycle();
    checkGrants("T3 aref first", 3'b100);
    ar_req = 1'b0; ar_end = 1'b1;
    nextCycle();
    ar_end = 1'b0;
    checkGrants("T3 arbit gap 1", 3'b000);
    nextCycle();
    checkGrants("T3 write second", 3'b010);
    wr_sdram_en = 1'b1; wr_data = 16'hA5A5;
    #1;
    checkOutput("T5 dq_oe write", 32'(sdram_dq_oe), 32'd1);
    checkOutput("T5 dq_out", 32'(sdram_dq_out), 32'hA5A5);
    ar_req = 1'b1;
    nextCycle();
    checkGrants("T4 no preempt", 3'b010);
    wr_req = 1'b0; wr_end = 1'b1;
    nextCycle();
    wr_end = 1'b0;
    checkGrants("T4 arbit gap", 3'b000);
    nextCycle();
    checkGrants("T4 aref after write", 3'b100);
    ar_req = 1'b0; ar_end = 1'b1;
    nextCycle();
    ar_end = 1'b0;
    nextCycle();
    checkGrants("T3 read last", 3'b001);
    wr_sdram_en = 1'b1;
    #1;
    checkOutput("T5 dq_oe read", 32'(sdram_dq_oe), 32'd0);
    wr_end = 1'b1;
    nextCycle();
    wr_end = 1'b0;
    checkGrants("foreign end ignored", 3'b001);
    rd_req = 1'b0; rd_end = 1'b1;
    nextCycle();
    rd_end = 1'b0;
    checkGrants("T3 read done", 3'b000);

    // T6: async reset in the middle of a refresh
    ar_req = 1'b1;
    nextCycle();
    checkGrants("T6 aref", 3'b100);
    #3;
    ar_rst_n = 1'b0; init_end = 1'b0;
    #1;
    checkGrants("T6 async drop", 3'b000);
    checkOutput("T6 cke low", 32'(sdram_cke), 32'd0);
    checkCmd("T6 init mux", 4'b0010);
    nextCycle();
    ar_rst_n = 1'b1;
    nextCycle();
    nextCycle();
    checkGrants("T6 held before init", 3'b000);
    init_end = 1'b1;
    nextCycle();
    nextCycle();
    checkGrants("T6 pending granted", 3'b100);
    ar_req = 1'b0; ar_end = 1'b1;
    nextCycle();
    ar_end = 1'b0;

    // Randomized phase. Occasional resets drop init_end for a few cycles.
    initWait = 0;
    for (int i = 0; i < 3000; i++) begin
      nextCycle();
      applyStimulus();
      ar_req = ($urandom_range(0, 9) < 2);
      wr_req = ($urandom_range(0, 9) < 4);
      rd_req = ($urandom_range(0, 9) < 4);
      ar_end = ($urandom_range(0, 5) == 0);
      wr_end = ($urandom_range(0, 5) == 0);
      rd_end = ($urandom_range(0, 5) == 0);
      if (i % 600 == 300) begin
        #2;
        ar_rst_n = 1'b0;
        init_end = 1'b0;
        initWait = int'($urandom_range(1, 5));
      end else begin
        ar_rst_n = 1'b1;
        if (initWait > 0) initWait--;
        else init_end = 1'b1;
      end
    end

    nextCycle();
    cmpEn = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
